cla_adder_pipe: RTL and testbench
=================================

CLA_ADDER_PIPE -- requirements
Module: cla_adder_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width; it is a multiple of GROUP, range 4..64.
REQ-002 The block SHALL have parameter GROUP, default 4, giving the bits per carry-lookahead group.
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 in_valid  input  1  operand set presented.
REQ-007 in_ready  output  1  block accepts an operand set this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry in; ignored when sub=1.
REQ-011 sub  input  1  0 = add, 1 = subtract (a - b).
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream consumes the result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry out of the MSB; in sub mode, 1 = no borrow.
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 The block SHALL compute the effective operands as: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin; {cout,raw} = a + b_eff + c0, modulo 2^(WIDTH+1).
REQ-018 Carries SHALL use two-level lookahead: per-bit p=a^b_eff, g=a&b_eff; per-group PG/GG; inter-group carries from GG, PG and c0. No ripple across groups.
REQ-019 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-020 The pipeline SHALL have two stages: stage 1 registers p, g, group PG/GG, c0 and a valid bit; stage 2 computes carries and registers sum, cout, ovf and out_valid.
REQ-021 Stage enables SHALL be s2_en = !out_valid | out_ready and s1_en = !s1_valid | s2_en, with in_ready = s1_en (combinational).
REQ-022 A transfer SHALL occur when in_valid & in_ready; an output transfer SHALL occur when out_valid & out_ready.
REQ-023 With no stall, out_valid SHALL assert 2 cycles after the accepting edge; throughput SHALL be 1 result per cycle.
REQ-024 While out_valid & !out_ready, sum, cout and ovf SHALL hold stable; with both stages full, in_ready SHALL be 0; no result is dropped or duplicated; order SHALL be preserved.
REQ-025 On simultaneous output consume and input accept with a full pipe, both transfers SHALL occur in the same cycle and the pipe SHALL stay full.
REQ-026 Stage registers SHALL load only on their enable; invalid bubbles SHALL not update sum, cout or ovf.

Reset
REQ-027 Asserting rst SHALL immediately clear s1_valid and out_valid and set sum=0, cout=0, ovf=0, regardless of the clock.
REQ-028 In-flight operations SHALL be discarded on reset; in_ready SHALL be 1 during and after reset.
REQ-029 The first accept after rst deasserts SHALL produce out_valid exactly 2 cycles later, with no stale data.

Configuration
REQ-030 The block SHALL support the macro CLA_SAT_EN: when defined, an overflowing result SHALL saturate to the signed extreme in stage 2. Positive overflow (MSB of a and b_eff both 0) gives 0111..1; negative overflow gives 1000..0.
REQ-031 When CLA_SAT_EN is undefined, sum SHALL equal raw (wrap-around).
REQ-032 In both configurations, ovf and cout SHALL report the unsaturated result, and latency SHALL be unchanged.

Verification (WIDTH=16, GROUP=4)
REQ-033 a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, out_valid 2 cycles after accept.
REQ-034 a=0x7FFF, b=0x0001, add -> ovf=1; sum=0x8000 without CLA_SAT_EN, 0x7FFF with it.
REQ-035 a=0x8000, b=0x8000, add -> cout=1, ovf=1; sum=0x0000 without CLA_SAT_EN, 0x8000 with it.
REQ-036 a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
REQ-037 Stream 6 back-to-back sets with out_ready=0 for cycles 3-5 -> in_ready=0 once 2 entries are held; all 6 results emerge in order and match a reference model.
REQ-038 Assert rst mid-cycle with 2 operations in flight -> out_valid=0 and sum=0 before the next clk edge; after release, the next accepted op is the first result seen.

Source files
------------

// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - two-stage pipelined carry-lookahead adder/subtractor
// Define CLA_SAT_EN to saturate signed overflow in stage 2 (ovf/cout stay unsaturated).
module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NG = WIDTH / GROUP;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_d, g_d, p_q, g_q;
  logic [NG-1:0]    pg_d, gg_d, pg_q, gg_q;
  logic             c0_d, c0_q;
  logic             s1_valid_q;
  logic             s1_en, s2_en;
  logic             t1, t2, acc;
  logic [NG:0]      cg;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, ovf_d, cout_q, ovf_q;
  logic             out_valid_q;

  assign s2_en    = !out_valid_q | out_ready;
  assign s1_en    = !s1_valid_q | s2_en;
  assign in_ready = s1_en;

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Stage 1: per-bit propagate/generate and per-group PG/GG in sum-of-products form.
  always_comb begin
    t1    = 1'b0;
    b_eff = sub ? ~b : b;
    c0_d  = sub ? 1'b1 : cin;
    p_d   = a ^ b_eff;
    g_d   = a & b_eff;
    pg_d  = '0;
    gg_d  = '0;
    for (int k = 0; k < NG; k++) begin
      pg_d[k] = &p_d[k*GROUP +: GROUP];
      for (int i = 0; i < GROUP; i++) begin
        t1 = g_d[k*GROUP+i];
        for (int m = i + 1; m < GROUP; m++) t1 = t1 & p_d[k*GROUP+m];
        gg_d[k] = gg_d[k] | t1;
      end
    end
  end

  // Stage 2: each group carry expanded directly from GG/PG/c0, then bit carries from it.
  always_comb begin
    t2  = 1'b0;
    acc = 1'b0;
    cg  = '0;
    c   = '0;
    for (int k = 0; k <= NG; k++) begin
      acc = c0_q;
      for (int m = 0; m < k; m++) acc = acc & pg_q[m];
      for (int j = 0; j < k; j++) begin
        t2 = gg_q[j];
        for (int m = j + 1; m < k; m++) t2 = t2 & pg_q[m];
        acc = acc | t2;
      end
      cg[k] = acc;
    end
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        acc = cg[k];
        for (int m = 0; m < i; m++) acc = acc & p_q[k*GROUP+m];
        for (int j = 0; j < i; j++) begin
          t2 = g_q[k*GROUP+j];
          for (int m = j + 1; m < i; m++) t2 = t2 & p_q[k*GROUP+m];
          acc = acc | t2;
        end
        c[k*GROUP+i] = acc;
      end
    end
    c[WIDTH] = cg[NG];
    raw      = p_q ^ c[WIDTH-1:0];
    cout_d   = c[WIDTH];
    ovf_d    = c[WIDTH] ^ c[WIDTH-1];
`ifdef CLA_SAT_EN
    // Overflow implies equal operand MSBs, so g of the MSB tells the direction.
    if (ovf_d)
      sum_d = g_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      sum_d = raw;
`else
    sum_d = raw;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      p_q         <= '0;
      g_q         <= '0;
      pg_q        <= '0;
      gg_q        <= '0;
      c0_q        <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          p_q  <= p_d;
          g_q  <= g_d;
          pg_q <= pg_d;
          gg_q <= gg_d;
          c0_q <= c0_d;
        end
      end
      if (s2_en) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sum_q  <= sum_d;
          cout_q <= cout_d;
          ovf_q  <= ovf_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - scoreboard bench for cla_adder_pipe
// Honours CLA_SAT_EN when it is defined for the build.
module tb_cla_adder_pipe;
  localparam int WIDTH = 16;
  localparam int GROUP = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_checks = 0;
  int n_pass = 0;
  int n_out = 0;
  int n0 = 0;
  int idx = 0;
  int sent = 0;
  logic hs = 1'b0;
  logic [WIDTH-1:0] held = '0;
  logic [WIDTH+1:0] exp_q[$];

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Returns {sum, cout, ovf} from plain wide arithmetic.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                             input logic ci, input logic sb);
    logic [WIDTH-1:0] be, r, s;
    logic [WIDTH:0]   full;
    logic             c0, ov;
    be   = sb ? ~bv : bv;
    c0   = sb ? 1'b1 : ci;
    full = {1'b0, av} + {1'b0, be} + {{WIDTH{1'b0}}, c0};
    r    = full[WIDTH-1:0];
    ov   = (av[WIDTH-1] == be[WIDTH-1]) && (r[WIDTH-1] != av[WIDTH-1]);
    s    = r;
`ifdef CLA_SAT_EN
    if (ov) s = av[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return {s, full[WIDTH], ov};
  endfunction

  always @(negedge clk) begin : monitor
    logic [WIDTH+1:0] e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_out++;
        check_eq("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("sb_sum", sum, e[WIDTH+1:2]);
          check_eq("sb_cout", cout, e[1]);
          check_eq("sb_ovf", ovf, e[0]);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic ci, input logic sb);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check_eq("send_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic ci, input logic sb,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    send(av, bv, ci, sb);
    @(negedge clk);
    check_eq({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({tag, "_lat2"}, out_valid, 1);
    check_eq({tag, "_sum"}, sum, es);
    check_eq({tag, "_cout"}, cout, ec);
    check_eq({tag, "_ovf"}, ovf, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_cout", cout, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("post_rst_ready", in_ready, 1);

    directed("d_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef CLA_SAT_EN
    directed("d_posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    directed("d_negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1);
`else
    directed("d_posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("d_negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
`endif
    directed("d_sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Six back-to-back sets with the consumer stalled in cycles 3-5.
    n0 = n_out;
    idx = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (idx < 6) begin
        in_valid = 1'b1;
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc == 3) held = sum;
      if (cyc == 4) check_eq("stall_in_ready", in_ready, 0);
      if (cyc == 5) begin
        check_eq("stall_hold_sum", sum, held);
        check_eq("stall_out_valid", out_valid, 1);
      end
      if (cyc == 6) check_eq("full_pass_ready", in_ready, 1);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    check_eq("stream_accepted", idx, 6);
    check_eq("stream_outputs", n_out - n0, 6);
    check_eq("stream_drain", exp_q.size(), 0);

    // Random traffic with random backpressure.
    sent = 0;
    for (int cyc = 0; cyc < 400 && sent < 40; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        in_valid = 1'b1;
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rand_sent", sent, 40);
    check_eq("rand_drain", exp_q.size(), 0);

    // Reset with two operations in flight.
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    send(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    #2;
    check_eq("pre_rst_valid", out_valid, 1);
    check_eq("pre_rst_sum", sum, 16'h2345);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_sum", sum, 0);
    check_eq("mid_rst_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    n0 = n_out;
    directed("d_after_rst", 16'h0202, 16'h0303, 1'b1, 1'b0, 16'h0506, 1'b0, 1'b0);
    check_eq("after_rst_count", n_out - n0, 1);
    check_eq("after_rst_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
